// File: rtl/projectile_sprite_engine.sv
// Player projectile engine: owns NUM_SHOTS slots, spawns them on fire,
// moves them up once per frame_tick, and renders the sprite for the current
// DrawX/DrawY through a fixed 2-stage pipeline (no stalls).
// Slot priority: a fire into a free slot wins, then kill, then the frame move.
module projectile_sprite_engine #(
   parameter int NUM_SHOTS  = 2,
   parameter int SPR_W      = 3,
   parameter int SPR_H      = 8,
   parameter int NUM_FRAMES = 2,
   parameter int ANIM_DIV   = 4,
   parameter int SPEED      = 4
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 frame_tick,
   input  logic                 fire,
   input  logic [9:0]           fire_x,
   input  logic [9:0]           fire_y,
   output logic                 fire_ack,
   input  logic [NUM_SHOTS-1:0] kill,
   output logic [NUM_SHOTS-1:0] shots_active,
   input  logic [9:0]           DrawX,
   input  logic [9:0]           DrawY,
   input  logic                 pix_valid_in,
   output logic                 pix_valid_out,
   output logic                 sprite_on,
   output logic [7:0]           SpriteR,
   output logic [7:0]           SpriteG,
   output logic [7:0]           SpriteB
);

   localparam int IW  = (NUM_SHOTS > 1) ? $clog2(NUM_SHOTS) : 1;
   localparam int AW  = (ANIM_DIV > 1)  ? $clog2(ANIM_DIV)  : 1;
   localparam int DXW = (SPR_W > 1)     ? $clog2(SPR_W)     : 1;
   localparam int DYW = (SPR_H > 1)     ? $clog2(SPR_H)     : 1;

   // Pattern ROM: row packed as {dx0, dx1, dx2}, 2 bits each.
   // Pattern 1 differs from pattern 0 only in the two top rows (tip flicker).
   function automatic logic [1:0] rom_idx(input logic pat,
                                          input logic [DYW-1:0] r,
                                          input logic [DXW-1:0] c);
      logic [5:0] row;
      row = 6'b00_11_00;
      case (int'(r))
         0, 1:    row = pat ? 6'b00_10_00 : 6'b00_01_00;
         2:       row = 6'b01_01_01;
         3:       row = 6'b01_10_01;
         default: row = 6'b00_11_00;
      endcase
      case (int'(c))
         0:       rom_idx = row[5:4];
         1:       rom_idx = row[3:2];
         2:       rom_idx = row[1:0];
         default: rom_idx = 2'b00;
      endcase
   endfunction

   logic [NUM_SHOTS-1:0] active;
   logic [9:0]           x [NUM_SHOTS];
   logic [9:0]           y [NUM_SHOTS];
   logic [AW-1:0]        anim_cnt;
   logic [1:0]           anim_frame;

   logic                 free_found;
   logic [IW-1:0]        free_idx;
   logic                 spawn;

   logic [9:0]           dx_all [NUM_SHOTS];
   logic [9:0]           dy_all [NUM_SHOTS];
   logic                 hit_c;
   logic [DXW-1:0]       dx_c;
   logic [DYW-1:0]       dy_c;

   logic                 s1_hit;
   logic [DXW-1:0]       s1_dx;
   logic [DYW-1:0]       s1_dy;
   logic                 s1_pat;
   logic                 s1_valid;
   logic [1:0]           s2_idx;

   assign shots_active = active;
   assign spawn        = fire && free_found;

   // Lowest-index inactive slot, from slot state at the start of the cycle.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = NUM_SHOTS - 1; i >= 0; i--) begin
         if (!active[i]) begin
            free_found = 1'b1;
            free_idx   = IW'(i);
         end
      end
   end

   // Slot state: spawn, kill, then upward move / leave-top on frame_tick.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         active   <= '0;
         fire_ack <= 1'b0;
         for (int i = 0; i < NUM_SHOTS; i++) begin
            x[i] <= '0;
            y[i] <= '0;
         end
      end else begin
         fire_ack <= spawn;
         for (int i = 0; i < NUM_SHOTS; i++) begin
            if (spawn && (free_idx == IW'(i))) begin
               active[i] <= 1'b1;
               x[i]      <= fire_x;
               y[i]      <= fire_y;
            end else if (kill[i]) begin
               active[i] <= 1'b0;
            end else if (frame_tick && active[i]) begin
               if (y[i] >= 10'(SPEED)) y[i] <= y[i] - 10'(SPEED);
               else                    active[i] <= 1'b0;
            end
         end
      end
   end

   // Animation: step anim_frame every ANIM_DIV frame ticks.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         anim_cnt   <= '0;
         anim_frame <= '0;
      end else if (frame_tick) begin
         if (anim_cnt == AW'(ANIM_DIV - 1)) begin
            anim_cnt   <= '0;
            anim_frame <= (anim_frame == 2'(NUM_FRAMES - 1)) ? 2'd0 : anim_frame + 2'd1;
         end else begin
            anim_cnt <= anim_cnt + AW'(1);
         end
      end
   end

   // Per-slot offsets of the current pixel (10-bit wrap, so left/above is huge).
   always_comb begin
      for (int i = 0; i < NUM_SHOTS; i++) begin
         dx_all[i] = DrawX - x[i];
         dy_all[i] = DrawY - y[i];
      end
   end

   // Hit search; scanning downward lets the lowest-index hit win.
   always_comb begin
      hit_c = 1'b0;
      dx_c  = '0;
      dy_c  = '0;
      for (int i = NUM_SHOTS - 1; i >= 0; i--) begin
         if (active[i] && (dx_all[i] < 10'(SPR_W)) && (dy_all[i] < 10'(SPR_H))) begin
            hit_c = 1'b1;
            dx_c  = dx_all[i][DXW-1:0];
            dy_c  = dy_all[i][DYW-1:0];
         end
      end
   end

   // Render stage 1: register hit, in-sprite offset, pattern and valid.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         s1_hit   <= 1'b0;
         s1_dx    <= '0;
         s1_dy    <= '0;
         s1_pat   <= 1'b0;
         s1_valid <= 1'b0;
      end else begin
         s1_hit   <= hit_c;
         s1_dx    <= dx_c;
         s1_dy    <= dy_c;
         s1_pat   <= anim_frame[0];
         s1_valid <= pix_valid_in;
      end
   end

   assign s2_idx = rom_idx(s1_pat, s1_dy, s1_dx);

   // Render stage 2: ROM/palette lookup; transparent or no hit renders black.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         pix_valid_out <= 1'b0;
         sprite_on     <= 1'b0;
         SpriteR       <= 8'h00;
         SpriteG       <= 8'h00;
         SpriteB       <= 8'h00;
      end else begin
         pix_valid_out <= s1_valid;
         sprite_on     <= s1_hit && (s2_idx != 2'd0);
         SpriteR       <= 8'h00;
         SpriteG       <= 8'h00;
         SpriteB       <= 8'h00;
         if (s1_hit) begin
            case (s2_idx)
               2'd1: SpriteR <= 8'hFF;
               2'd2: begin
                  SpriteR <= 8'hFF;
                  SpriteG <= 8'hFF;
                  SpriteB <= 8'hFF;
               end
               2'd3: begin
                  SpriteR <= 8'hDE;
                  SpriteG <= 8'hDE;
                  SpriteB <= 8'hDE;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_projectile_sprite_engine.sv
// Bench for projectile_sprite_engine: slot/animation/pixel model built from
// the behavioural rules, a per-cycle compare process, and literal spot checks.
module tb_projectile_sprite_engine;

   localparam int NS         = 2;
   localparam int SPR_W      = 3;
   localparam int SPR_H      = 8;
   localparam int NUM_FRAMES = 2;
   localparam int ANIM_DIV   = 4;
   localparam int SPEED      = 4;

   logic          Clk, Reset, frame_tick, fire, pix_valid_in;
   logic [9:0]    fire_x, fire_y, DrawX, DrawY;
   logic [NS-1:0] kill;
   logic          fire_ack, pix_valid_out, sprite_on;
   logic [NS-1:0] shots_active;
   logic [7:0]    SpriteR, SpriteG, SpriteB;

   projectile_sprite_engine #(
      .NUM_SHOTS(NS), .SPR_W(SPR_W), .SPR_H(SPR_H),
      .NUM_FRAMES(NUM_FRAMES), .ANIM_DIV(ANIM_DIV), .SPEED(SPEED)
   ) dut (
      .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .fire(fire),
      .fire_x(fire_x), .fire_y(fire_y), .fire_ack(fire_ack), .kill(kill),
      .shots_active(shots_active), .DrawX(DrawX), .DrawY(DrawY),
      .pix_valid_in(pix_valid_in), .pix_valid_out(pix_valid_out),
      .sprite_on(sprite_on), .SpriteR(SpriteR), .SpriteG(SpriteG), .SpriteB(SpriteB)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic check_en = 1'b0;

   string pat0 [8] = '{"010", "010", "111", "121", "030", "030", "030", "030"};
   string pat1 [8] = '{"020", "020", "111", "121", "030", "030", "030", "030"};

   // Model state (start-of-cycle view) and expected registered outputs.
   logic [NS-1:0] m_act;
   logic [9:0]    m_x [NS];
   logic [9:0]    m_y [NS];
   int            m_ticks;
   logic          exp_ack, exp_v, exp_on;
   logic [NS-1:0] exp_act;
   logic [23:0]   exp_rgb;
   logic          p1_v, p1_on;
   logic [23:0]   p1_rgb;
   // Next-state scratch.
   logic [NS-1:0] n_act;
   logic [9:0]    n_x [NS];
   logic [9:0]    n_y [NS];
   int            n_ticks;
   logic          n_ack, n_v, n_on, n_p1_v, n_p1_on;
   logic [23:0]   n_rgb, n_p1_rgb;

   function automatic int pat_pix(int p, int r, int c);
      string s;
      s = (p == 0) ? pat0[r] : pat1[r];
      return int'(s[c]) - 48;
   endfunction

   function automatic logic [23:0] pal(int k);
      case (k)
         1:       return 24'hFF0000;
         2:       return 24'hFFFFFF;
         3:       return 24'hDEDEDE;
         default: return 24'h000000;
      endcase
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_act = '0; m_ticks = 0;
      for (int i = 0; i < NS; i++) begin m_x[i] = '0; m_y[i] = '0; end
      exp_ack = 1'b0; exp_act = '0; exp_v = 1'b0; exp_on = 1'b0; exp_rgb = '0;
      p1_v = 1'b0; p1_on = 1'b0; p1_rgb = '0;
   endtask

   // Next model state from current model state and the inputs driven now.
   task automatic model_step();
      int free_i, frame, idx;
      logic found, on;
      logic [9:0] ddx, ddy;
      logic [23:0] rgb;
      free_i = -1;
      for (int i = 0; i < NS; i++) if (!m_act[i] && free_i < 0) free_i = i;
      frame = (m_ticks / ANIM_DIV) % NUM_FRAMES;
      found = 1'b0; on = 1'b0; rgb = '0;
      for (int i = 0; i < NS; i++) begin
         if (!found && m_act[i]) begin
            ddx = DrawX - m_x[i];
            ddy = DrawY - m_y[i];
            if (ddx < 10'(SPR_W) && ddy < 10'(SPR_H)) begin
               found = 1'b1;
               idx   = pat_pix(frame % 2, int'(ddy), int'(ddx));
               on    = (idx != 0);
               rgb   = on ? pal(idx) : 24'h0;
            end
         end
      end
      n_v = p1_v; n_on = p1_on; n_rgb = p1_rgb;
      n_p1_v = pix_valid_in; n_p1_on = on; n_p1_rgb = rgb;
      n_ack   = fire && (free_i >= 0);
      n_ticks = m_ticks + (frame_tick ? 1 : 0);
      for (int i = 0; i < NS; i++) begin
         n_act[i] = m_act[i]; n_x[i] = m_x[i]; n_y[i] = m_y[i];
         if (fire && free_i == i) begin
            n_act[i] = 1'b1; n_x[i] = fire_x; n_y[i] = fire_y;
         end else if (kill[i]) begin
            n_act[i] = 1'b0;
         end else if (frame_tick && m_act[i]) begin
            if (m_y[i] >= 10'(SPEED)) n_y[i] = m_y[i] - 10'(SPEED);
            else                      n_act[i] = 1'b0;
         end
      end
   endtask

   task automatic cyc();
      model_step();
      @(posedge Clk);
      m_act = n_act; m_ticks = n_ticks;
      for (int i = 0; i < NS; i++) begin m_x[i] = n_x[i]; m_y[i] = n_y[i]; end
      exp_ack = n_ack; exp_act = n_act;
      exp_v = n_v; exp_on = n_on; exp_rgb = n_rgb;
      p1_v = n_p1_v; p1_on = n_p1_on; p1_rgb = n_p1_rgb;
      #2;
   endtask

   task automatic probe(input logic [9:0] px, input logic [9:0] py);
      DrawX = px; DrawY = py; pix_valid_in = 1'b1;
      cyc();
      pix_valid_in = 1'b0;
      cyc();
   endtask

   // Per-cycle comparison of every output against the model.
   always @(negedge Clk) begin
      if (check_en) begin
         cmp("fire_ack", 32'(fire_ack), 32'(exp_ack));
         cmp("shots_active", 32'(shots_active), 32'(exp_act));
         cmp("pix_valid_out", 32'(pix_valid_out), 32'(exp_v));
         cmp("sprite_on", 32'(sprite_on), 32'(exp_on));
         cmp("rgb", 32'({SpriteR, SpriteG, SpriteB}), 32'(exp_rgb));
      end
   end

   initial begin
      Reset = 1'b1; frame_tick = 1'b0; fire = 1'b0; fire_x = '0; fire_y = '0;
      kill = '0; DrawX = '0; DrawY = '0; pix_valid_in = 1'b0;
      model_reset();
      repeat (3) @(posedge Clk);
      #2;
      cmp("rst_shots", 32'(shots_active), 32'h0);
      cmp("rst_ack", 32'(fire_ack), 32'h0);
      cmp("rst_pvo", 32'(pix_valid_out), 32'h0);
      cmp("rst_rgb", 32'({sprite_on, SpriteR, SpriteG, SpriteB}), 32'h0);
      Reset = 1'b0;
      check_en = 1'b1;

      // Single spawn and render of its top rows.
      fire = 1'b1; fire_x = 10'd100; fire_y = 10'd400;
      cyc();
      fire = 1'b0;
      cmp("t1_ack", 32'(fire_ack), 32'h1);
      cmp("t1_shots", 32'(shots_active), 32'h1);
      DrawX = 10'd101; DrawY = 10'd400; pix_valid_in = 1'b1;
      cyc();
      DrawX = 10'd100;
      cyc();
      cmp("t1_on", 32'(sprite_on), 32'h1);
      cmp("t1_red", 32'({SpriteR, SpriteG, SpriteB}), 32'hFF0000);
      pix_valid_in = 1'b0;
      cyc();
      cmp("t1_transparent", 32'(sprite_on), 32'h0);
      cmp("t1_pvo", 32'(pix_valid_out), 32'h1);

      // Three back-to-back fires into two slots; third is dropped.
      kill = 2'b01;
      cyc();
      kill = 2'b00;
      cmp("t2_cleared", 32'(shots_active), 32'h0);
      fire = 1'b1; fire_x = 10'd50; fire_y = 10'd50;
      cyc();
      cmp("t2_ack0", 32'(fire_ack), 32'h1);
      fire_x = 10'd51;
      cyc();
      cmp("t2_ack1", 32'(fire_ack), 32'h1);
      cmp("t2_shots", 32'(shots_active), 32'h3);
      fire_x = 10'd200; fire_y = 10'd200;
      cyc();
      fire = 1'b0;
      cmp("t2_ack2", 32'(fire_ack), 32'h0);
      // Overlap: slot 0 at dx=1,dy=3 beats slot 1.
      probe(10'd51, 10'd53);
      cmp("t2_overlap", 32'({SpriteR, SpriteG, SpriteB}), 32'hFFFFFF);

      // Move to y=2, then leave the top.
      kill = 2'b11;
      cyc();
      kill = 2'b00;
      fire = 1'b1; fire_x = 10'd300; fire_y = 10'd6;
      cyc();
      fire = 1'b0; frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      probe(10'd301, 10'd5);
      cmp("t3_moved_white", 32'({SpriteR, SpriteG, SpriteB}), 32'hFFFFFF);
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      cmp("t3_offtop", 32'(shots_active), 32'h0);
      probe(10'd301, 10'd5);
      cmp("t3_gone", 32'(sprite_on), 32'h0);

      // Animation: 4 ticks total -> pattern 1, 8 ticks -> pattern 0.
      fire = 1'b1; fire_x = 10'd400; fire_y = 10'd300;
      cyc();
      fire = 1'b0; frame_tick = 1'b1;
      cyc();
      cyc();
      frame_tick = 1'b0;
      probe(10'd401, 10'd292);
      cmp("t5_pat1", 32'({SpriteR, SpriteG, SpriteB}), 32'hFFFFFF);
      frame_tick = 1'b1;
      for (int k = 0; k < 4; k++) cyc();
      frame_tick = 1'b0;
      probe(10'd401, 10'd276);
      cmp("t5_pat0", 32'({SpriteR, SpriteG, SpriteB}), 32'hFF0000);

      // Kill beats tick; killed slot is not free for a same-cycle fire.
      fire = 1'b1; fire_x = 10'd20; fire_y = 10'd100;
      cyc();
      kill = 2'b01; frame_tick = 1'b1; fire_x = 10'd5; fire_y = 10'd5;
      cyc();
      kill = 2'b00; frame_tick = 1'b0; fire = 1'b0;
      cmp("t6_shots", 32'(shots_active), 32'h2);
      cmp("t6_ack", 32'(fire_ack), 32'h0);
      DrawX = 10'd21; DrawY = 10'd96; pix_valid_in = 1'b1;
      cyc();
      cyc();
      cmp("t6_red", 32'({SpriteR, SpriteG, SpriteB}), 32'hFF0000);

      // Asynchronous reset in the middle of a valid pixel stream.
      #1;
      Reset = 1'b1;
      model_reset();
      #1;
      cmp("ar_shots", 32'(shots_active), 32'h0);
      cmp("ar_ack", 32'(fire_ack), 32'h0);
      cmp("ar_pvo", 32'(pix_valid_out), 32'h0);
      cmp("ar_on", 32'(sprite_on), 32'h0);
      cmp("ar_rgb", 32'({SpriteR, SpriteG, SpriteB}), 32'h0);
      @(posedge Clk);
      #2;
      Reset = 1'b0;
      cyc();
      cyc();
      cmp("ar_pvo_back", 32'(pix_valid_out), 32'h1);
      cmp("ar_dark", 32'(sprite_on), 32'h0);
      pix_valid_in = 1'b0;
      cyc();
      cyc();

      check_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
